ysyx_22040895_trap_ctrl: RTL and testbench

Trap sequencer sitting directly upstream of the CSR file. Accepts ecall/ebreak/mret events from the execute stage, drives the CSR file's dedicated mepc/mcause/mtvec/mstatus set/get ports in the correct order, and issues a held PC redirect to the fetch stage. Stalls the pipeline while a trap or return is in flight.

---
 rtl/ysyx_22040895_trap_ctrl_if.sv | 59 +++++
 rtl/ysyx_22040895_trap_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22040895_trap_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_trap_ctrl_if.sv
// Trap sequencer bus bundle: execute-stage event handshake, CSR set/get ports and fetch redirect.
interface ysyx_22040895_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            ev_valid_i;
    logic            ev_ready_o;
    logic            ecall_i;
    logic            ebreak_i;
    logic            mret_i;
    logic [XLEN-1:0] pc_i;

    logic            set_mepc_o;
    logic [XLEN-1:0] wdata_mepc_o;
    logic            get_mepc_o;
    logic [XLEN-1:0] rdata_mepc_i;
    logic            set_mcause_o;
    logic [XLEN-1:0] wdata_mcause_o;
    logic            get_mtvec_o;
    logic [XLEN-1:0] rdata_mtvec_i;
    logic            set_mstatus_o;
    logic [XLEN-1:0] wdata_mstatus_o;
    logic            get_mstatus_o;
    logic [XLEN-1:0] rdata_mstatus_i;

    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;
    logic            stall_o;

    // master: the trap sequencer itself
    modport master (
        input  ev_valid_i, ecall_i, ebreak_i, mret_i, pc_i,
        output ev_ready_o,
        output set_mepc_o, wdata_mepc_o, get_mepc_o,
        input  rdata_mepc_i,
        output set_mcause_o, wdata_mcause_o, get_mtvec_o,
        input  rdata_mtvec_i,
        output set_mstatus_o, wdata_mstatus_o, get_mstatus_o,
        input  rdata_mstatus_i,
        output redirect_valid_o, redirect_pc_o,
        input  redirect_ready_i,
        output stall_o
    );

    // slave: execute stage, CSR file and fetch stage around it
    modport slave (
        output ev_valid_i, ecall_i, ebreak_i, mret_i, pc_i,
        input  ev_ready_o,
        input  set_mepc_o, wdata_mepc_o, get_mepc_o,
        output rdata_mepc_i,
        input  set_mcause_o, wdata_mcause_o, get_mtvec_o,
        output rdata_mtvec_i,
        input  set_mstatus_o, wdata_mstatus_o, get_mstatus_o,
        output rdata_mstatus_i,
        input  redirect_valid_o, redirect_pc_o,
        output redirect_ready_i,
        input  stall_o
    );
endinterface

// File: rtl/ysyx_22040895_trap_ctrl.sv
// Trap/return sequencer in front of the CSR file: ecall/ebreak/mret -> CSR updates -> held fetch redirect.
// Optional macro TRAP_TIMER_IRQ_EN adds timer_irq_i, taken in IDLE when mstatus.MIE is set.
module ysyx_22040895_trap_ctrl #(
    parameter int          XLEN             = 64,
    parameter logic [63:0] MTVEC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC
) (
    input logic                       clk,
    input logic                       rst,
`ifdef TRAP_TIMER_IRQ_EN
    input logic                       timer_irq_i,
`endif
    ysyx_22040895_trap_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SAVE = 3'd1;
    localparam logic [2:0] S_JUMP = 3'd2;
    localparam logic [2:0] S_RET  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    localparam logic [XLEN-1:0] TVEC_MASK    = MTVEC_ALIGN_MASK[XLEN-1:0];
    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
`ifdef TRAP_TIMER_IRQ_EN
    localparam logic [XLEN-1:0] CAUSE_MTIRQ  = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);
`endif

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            is_idle;
    logic            irq_take;
    logic            ev_ready;
    logic            accept;

    assign is_idle = (state == S_IDLE);

`ifdef TRAP_TIMER_IRQ_EN
    // mstatus is read continuously in IDLE so MIE gates the interrupt without an extra cycle
    assign irq_take = is_idle & timer_irq_i & bus.rdata_mstatus_i[3];
`else
    assign irq_take = 1'b0;
`endif

    assign ev_ready = is_idle & ~irq_take;
    assign accept   = bus.ev_valid_i & ev_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (irq_take) begin
                    state_nxt = S_SAVE;
                end else if (accept) begin
                    if (bus.ecall_i | bus.ebreak_i) begin
                        state_nxt = S_SAVE;
                    end else if (bus.mret_i) begin
                        state_nxt = S_RET;
                    end
                end
            end
            S_SAVE:  state_nxt = S_JUMP;
            S_JUMP:  state_nxt = S_WAIT;
            S_RET:   state_nxt = S_WAIT;
            S_WAIT:  if (bus.redirect_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pc_q          <= '0;
            cause_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
`ifdef TRAP_TIMER_IRQ_EN
                    if (irq_take) begin
                        pc_q    <= bus.pc_i;
                        cause_q <= CAUSE_MTIRQ;
                    end else
`endif
                    if (accept) begin
                        pc_q    <= bus.pc_i;
                        cause_q <= bus.ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
                    end
                end
                // SAVE has already committed, so mtvec read here is current
                S_JUMP:  redirect_pc_q <= bus.rdata_mtvec_i & TVEC_MASK;
                S_RET:   redirect_pc_q <= bus.rdata_mepc_i;
                default: ;
            endcase
        end
    end

    logic            set_mepc;
    logic [XLEN-1:0] wdata_mepc;
    logic            get_mepc;
    logic            set_mcause;
    logic [XLEN-1:0] wdata_mcause;
    logic            get_mtvec;
    logic            set_mstatus;
    logic [XLEN-1:0] wdata_mstatus;
    logic            get_mstatus;

    // CSR strobes decode straight from state so an async reset drops them immediately
    always_comb begin
        set_mepc      = 1'b0;
        wdata_mepc    = '0;
        get_mepc      = 1'b0;
        set_mcause    = 1'b0;
        wdata_mcause  = '0;
        get_mtvec     = 1'b0;
        set_mstatus   = 1'b0;
        wdata_mstatus = '0;
        get_mstatus   = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef TRAP_TIMER_IRQ_EN
                get_mstatus = 1'b1;
`endif
            end
            S_SAVE: begin
                set_mepc      = 1'b1;
                wdata_mepc    = pc_q;
                set_mcause    = 1'b1;
                wdata_mcause  = cause_q;
                get_mstatus   = 1'b1;
                set_mstatus   = 1'b1;
                wdata_mstatus = trap_mstatus(bus.rdata_mstatus_i);
            end
            S_JUMP: begin
                get_mtvec = 1'b1;
            end
            S_RET: begin
                get_mepc      = 1'b1;
                get_mstatus   = 1'b1;
                set_mstatus   = 1'b1;
                wdata_mstatus = ret_mstatus(bus.rdata_mstatus_i);
            end
            default: ;
        endcase
    end

    assign bus.ev_ready_o       = ev_ready;
    assign bus.set_mepc_o       = set_mepc;
    assign bus.wdata_mepc_o     = wdata_mepc;
    assign bus.get_mepc_o       = get_mepc;
    assign bus.set_mcause_o     = set_mcause;
    assign bus.wdata_mcause_o   = wdata_mcause;
    assign bus.get_mtvec_o      = get_mtvec;
    assign bus.set_mstatus_o    = set_mstatus;
    assign bus.wdata_mstatus_o  = wdata_mstatus;
    assign bus.get_mstatus_o    = get_mstatus;
    assign bus.redirect_valid_o = (state == S_WAIT);
    assign bus.redirect_pc_o    = redirect_pc_q;
    assign bus.stall_o          = ~is_idle;

endmodule

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
// Directed bench for the trap sequencer with a small CSR register model on the CSR ports.
module tb_ysyx_22040895_trap_ctrl;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef TRAP_TIMER_IRQ_EN
    logic timer_irq = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    ysyx_22040895_trap_ctrl_if #(.XLEN(XLEN)) bus ();

    ysyx_22040895_trap_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TRAP_TIMER_IRQ_EN
        .timer_irq_i (timer_irq),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, write on the clock edge, plus a bench preload path
    logic [XLEN-1:0] mepc_r, mcause_r, mtvec_r, mstatus_r;
    logic            ld_en = 1'b0;
    logic [XLEN-1:0] ld_mepc, ld_mcause, ld_mtvec, ld_mstatus;

    always @(posedge clk) begin
        if (ld_en) begin
            mepc_r    <= ld_mepc;
            mcause_r  <= ld_mcause;
            mtvec_r   <= ld_mtvec;
            mstatus_r <= ld_mstatus;
        end else begin
            if (bus.set_mepc_o)    mepc_r    <= bus.wdata_mepc_o;
            if (bus.set_mcause_o)  mcause_r  <= bus.wdata_mcause_o;
            if (bus.set_mstatus_o) mstatus_r <= bus.wdata_mstatus_o;
        end
    end

    assign bus.rdata_mepc_i    = mepc_r;
    assign bus.rdata_mtvec_i   = mtvec_r;
    assign bus.rdata_mstatus_i = mstatus_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        bus.ev_valid_i = 1'b0;
        bus.ecall_i    = 1'b0;
        bus.ebreak_i   = 1'b0;
        bus.mret_i     = 1'b0;
    endtask

    task automatic preload(input logic [63:0] mepc, input logic [63:0] mcause,
                           input logic [63:0] mtvec, input logic [63:0] mstatus);
        ld_en      = 1'b1;
        ld_mepc    = mepc;
        ld_mcause  = mcause;
        ld_mtvec   = mtvec;
        ld_mstatus = mstatus;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        clear_ev();
        bus.pc_i             = '0;
        bus.redirect_ready_i = 1'b0;

        // reset state
        preload(64'h0, 64'h0, 64'h8000_1003, 64'h8);
        check("rst_ev_ready", bus.ev_ready_o, 1);
        check("rst_stall", bus.stall_o, 0);
        check("rst_redir_valid", bus.redirect_valid_o, 0);
        check("rst_redir_pc", bus.redirect_pc_o, 0);
        check("rst_set_mepc", bus.set_mepc_o, 0);
        check("rst_wdata_mstatus", bus.wdata_mstatus_o, 0);
        rst = 1'b1;
        tick();
`ifndef TRAP_TIMER_IRQ_EN
        check("idle_get_mstatus", bus.get_mstatus_o, 0);
`endif

        // ecall at cycle N
        bus.ev_valid_i = 1'b1;
        bus.ecall_i    = 1'b1;
        bus.pc_i       = 64'h8000_0010;
        #1;
        check("ecall_ev_ready", bus.ev_ready_o, 1);
        tick();
        clear_ev();
        check("save_set_mepc", bus.set_mepc_o, 1);
        check("save_wdata_mepc", bus.wdata_mepc_o, 64'h8000_0010);
        check("save_set_mcause", bus.set_mcause_o, 1);
        check("save_wdata_mcause", bus.wdata_mcause_o, 64'd11);
        check("save_set_mstatus", bus.set_mstatus_o, 1);
        check("save_wdata_mstatus", bus.wdata_mstatus_o, 64'h1880);
        check("save_stall", bus.stall_o, 1);
        check("save_ev_ready", bus.ev_ready_o, 0);
        check("save_redir_valid", bus.redirect_valid_o, 0);
        tick();
        check("jump_get_mtvec", bus.get_mtvec_o, 1);
        check("jump_set_mepc", bus.set_mepc_o, 0);
        check("jump_redir_valid", bus.redirect_valid_o, 0);
        check("csr_mepc", mepc_r, 64'h8000_0010);
        check("csr_mcause", mcause_r, 64'd11);
        check("csr_mstatus", mstatus_r, 64'h1880);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("wait_redir_valid", bus.redirect_valid_o, 1);
            check("wait_redir_pc", bus.redirect_pc_o, 64'h8000_1000);
            check("wait_stall", bus.stall_o, 1);
            check("wait_ev_ready", bus.ev_ready_o, 0);
            check("wait_no_set", {bus.set_mepc_o, bus.set_mcause_o, bus.set_mstatus_o}, 0);
            tick();
        end
        bus.redirect_ready_i = 1'b1;
        tick();
        bus.redirect_ready_i = 1'b0;
        check("ecall_done_valid", bus.redirect_valid_o, 0);
        check("ecall_done_stall", bus.stall_o, 0);
        check("ecall_done_ready", bus.ev_ready_o, 1);

        // mret
        preload(64'h8000_0014, 64'd11, 64'h8000_1003, 64'h1880);
        bus.ev_valid_i = 1'b1;
        bus.mret_i     = 1'b1;
        bus.pc_i       = 64'h8000_0040;
        tick();
        clear_ev();
        check("ret_get_mepc", bus.get_mepc_o, 1);
        check("ret_set_mstatus", bus.set_mstatus_o, 1);
        check("ret_wdata_mstatus", bus.wdata_mstatus_o, 64'h1888);
        check("ret_no_mepc_mcause", {bus.set_mepc_o, bus.set_mcause_o}, 0);
        check("ret_redir_valid", bus.redirect_valid_o, 0);
        bus.redirect_ready_i = 1'b1;
        tick();
        check("ret_wait_valid", bus.redirect_valid_o, 1);
        check("ret_wait_pc", bus.redirect_pc_o, 64'h8000_0014);
        tick();
        bus.redirect_ready_i = 1'b0;
        check("ret_done_valid", bus.redirect_valid_o, 0);
        check("ret_csr_mstatus", mstatus_r, 64'h1888);

        // ecall and mret together: ecall wins
        bus.ev_valid_i = 1'b1;
        bus.ecall_i    = 1'b1;
        bus.mret_i     = 1'b1;
        bus.pc_i       = 64'h8000_0100;
        tick();
        clear_ev();
        check("prio_set_mepc", bus.set_mepc_o, 1);
        check("prio_get_mepc", bus.get_mepc_o, 0);
        check("prio_wdata_mcause", bus.wdata_mcause_o, 64'd11);
        check("prio_wdata_mepc", bus.wdata_mepc_o, 64'h8000_0100);
        check("prio_wdata_mstatus", bus.wdata_mstatus_o, 64'h1880);
        tick();
        bus.redirect_ready_i = 1'b1;
        tick();
        check("prio_redir_pc", bus.redirect_pc_o, 64'h8000_1000);
        tick();
        bus.redirect_ready_i = 1'b0;
        check("prio_done_stall", bus.stall_o, 0);

        // ebreak, then reset in the middle of SAVE
        bus.ev_valid_i = 1'b1;
        bus.ebreak_i   = 1'b1;
        bus.pc_i       = 64'h8000_0200;
        tick();
        clear_ev();
        check("ebrk_wdata_mcause", bus.wdata_mcause_o, 64'd3);
        check("ebrk_wdata_mepc", bus.wdata_mepc_o, 64'h8000_0200);
        rst = 1'b0;
        #1;
        check("midrst_sets", {bus.set_mepc_o, bus.set_mcause_o, bus.set_mstatus_o}, 0);
        check("midrst_wdata", bus.wdata_mcause_o | bus.wdata_mepc_o | bus.wdata_mstatus_o, 0);
        check("midrst_stall", bus.stall_o, 0);
        check("midrst_ev_ready", bus.ev_ready_o, 1);
        tick();
        check("midrst_csr_mcause", mcause_r, 64'd11);
        rst = 1'b1;
        tick();
        check("postrst_ev_ready", bus.ev_ready_o, 1);
        check("postrst_redir_valid", bus.redirect_valid_o, 0);
        check("postrst_redir_pc", bus.redirect_pc_o, 0);

        // event with no flag is consumed without leaving IDLE
        bus.ev_valid_i = 1'b1;
        bus.pc_i       = 64'h8000_0300;
        tick();
        clear_ev();
        check("noflag_stall", bus.stall_o, 0);
        check("noflag_set_mepc", bus.set_mepc_o, 0);

`ifdef TRAP_TIMER_IRQ_EN
        // timer interrupt beats a simultaneous ecall
        preload(64'h0, 64'h0, 64'h8000_1003, 64'h8);
        timer_irq      = 1'b1;
        bus.ev_valid_i = 1'b1;
        bus.ecall_i    = 1'b1;
        bus.pc_i       = 64'h8000_0400;
        #1;
        check("irq_ev_ready", bus.ev_ready_o, 0);
        check("irq_get_mstatus", bus.get_mstatus_o, 1);
        tick();
        clear_ev();
        timer_irq = 1'b0;
        check("irq_wdata_mcause", bus.wdata_mcause_o, 64'h8000_0000_0000_0007);
        check("irq_wdata_mepc", bus.wdata_mepc_o, 64'h8000_0400);
        tick();
        bus.redirect_ready_i = 1'b1;
        tick();
        check("irq_redir_pc", bus.redirect_pc_o, 64'h8000_1000);
        tick();
        bus.redirect_ready_i = 1'b0;
        check("irq_done_stall", bus.stall_o, 0);
        check("irq_not_reentered", bus.set_mepc_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
